fetch_top: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues in-order word reads to instruction memory and buffers returned words in a small prefetch FIFO.

---
 rtl/utils_top_pkg.sv | 15 +
 rtl/fetch_imem_if.sv | 19 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_top.sv | 122 ++++++++++++
 tb/tb_fetch_top.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/utils_top_pkg.sv
// -----------------------------------------------------------------------------
// utils_top: shared constants and types for the instruction-fetch stage.
//   NOP_INST    : ADDI x0,x0,0, presented to decode whenever no word is valid
//   fetch_ent_t : one prefetch FIFO entry {instruction word, its PC}
// -----------------------------------------------------------------------------
package utils_top;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_ent_t;

endpackage

// File: rtl/fetch_imem_if.sv
// -----------------------------------------------------------------------------
// fetch_imem_if: instruction-memory read bus between fetch and imem.
//   req/addr : read request and word-aligned address (master -> slave)
//   gnt      : request accepted this cycle (req & gnt = handshake)
//   rvld     : read data valid, responses return in request order
//   rdata    : read data
// -----------------------------------------------------------------------------
interface fetch_imem_if;

   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvld;
   logic [31:0] rdata;

   modport master (output req, output addr, input gnt, input rvld, input rdata);
   modport slave  (input req, input addr, output gnt, output rvld, output rdata);

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo: synchronous prefetch FIFO of fetch_ent_t.
//   clk, rst : clock, async active-high reset
//   push     : write push_dat at the tail
//   pop      : drop the head entry (ignored when empty)
//   flush    : empty the FIFO; overrides push and pop
//   head     : oldest entry (contents undefined when empty)
//   cnt      : number of valid entries
//   empty    : cnt == 0
//   full     : cnt == DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
   import utils_top::*;
#(
   parameter int unsigned DEPTH = 2
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  fetch_ent_t                 push_dat,
   input  logic                       pop,
   input  logic                       flush,
   output fetch_ent_t                 head,
   output logic [$clog2(DEPTH+1)-1:0] cnt,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

   fetch_ent_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign empty  = (cnt == '0);
   assign full   = (cnt == DEPTH_C);
   assign do_pop = pop && !empty;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + CW'(push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: head is only consumed when the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/fetch_top.sv
// -----------------------------------------------------------------------------
// fetch_top: instruction-fetch stage. Owns the PC, issues in-order word reads
// to imem, buffers returned words in a prefetch FIFO and presents one
// instruction per cycle to decode. Execute redirects flush everything buffered
// or in flight.
//   clk, rst    : clock, async active-high reset
//   imem        : fetch_imem_if master (req/addr/gnt/rvld/rdata)
//   ex_redir    : redirect strobe from execute
//   ex_redir_pc : redirect target (low two bits ignored)
//   id_rdy      : decode accepts if_inst this cycle
//   if_vld      : if_inst/if_pc hold a real fetched instruction
//   if_inst     : instruction to decode, NOP_INST when if_vld=0
//   if_pc       : PC of if_inst, 0 when if_vld=0
//   if_bub_cnt  : saturating count of cycles with if_vld=0 when the macro
//                 FETCH_BUBBLE_CNT_EN is defined, otherwise tied to 0
// -----------------------------------------------------------------------------
module fetch_top
   import utils_top::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
)
(
   input  logic                clk,
   input  logic                rst,
   fetch_imem_if.master        imem,
   input  logic                ex_redir,
   input  logic [31:0]         ex_redir_pc,
   input  logic                id_rdy,
   output logic                if_vld,
   output logic [31:0]         if_inst,
   output logic [31:0]         if_pc,
   output logic [31:0]         if_bub_cnt
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
   localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

   logic [31:0]   pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outst;
   logic [CW-1:0] outst_nxt;
   logic [CW-1:0] drop;
   logic [CW-1:0] fifo_cnt;
   logic [CW:0]   credit_used;
   logic          hs;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;
   fetch_ent_t    push_dat;
   fetch_ent_t    head;

   // Every request holds a FIFO slot until its word is popped or dropped, so
   // the FIFO can never overflow.
   assign credit_used = {1'b0, outst} + {1'b0, fifo_cnt};
   assign imem.req    = !rst && !ex_redir && (credit_used < DEPTH_C);
   assign imem.addr   = pc;
   assign hs          = imem.req && imem.gnt;

   assign push     = imem.rvld && (drop == '0) && !ex_redir;
   assign pop      = if_vld && id_rdy && !ex_redir;
   assign push_dat = '{inst: imem.rdata, pc: resp_pc};

   always_comb begin
      outst_nxt = outst;
      if (hs && !imem.rvld)      outst_nxt = outst + 1'b1;
      else if (!hs && imem.rvld) outst_nxt = outst - 1'b1;
   end

   // resp_pc tracks the PC of the next word that will be kept; dropped words
   // do not advance it, so no per-request PC queue is needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= RESET_PC;
         resp_pc <= RESET_PC;
         outst   <= '0;
         drop    <= '0;
      end else begin
         outst <= outst_nxt;
         if (ex_redir) begin
            pc      <= ex_redir_pc & ~32'h3;
            resp_pc <= ex_redir_pc & ~32'h3;
            // outst + (req&gnt) - rvld: everything still in flight is stale.
            drop    <= outst_nxt;
         end else begin
            if (hs)                          pc      <= pc + 32'd4;
            if (push)                        resp_pc <= resp_pc + 32'd4;
            if (imem.rvld && (drop != '0))   drop    <= drop - 1'b1;
         end
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .flush    (ex_redir),
      .head     (head),
      .cnt      (fifo_cnt),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   assign if_vld  = !fifo_empty;
   assign if_inst = if_vld ? head.inst : NOP_INST;
   assign if_pc   = if_vld ? head.pc   : '0;

`ifdef FETCH_BUBBLE_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                if_bub_cnt <= '0;
      else if (!if_vld && (if_bub_cnt != '1)) if_bub_cnt <= if_bub_cnt + 32'd1;
   end
`else
   assign if_bub_cnt = '0;
`endif

   a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_top.sv
`timescale 1ns/1ps
module tb_fetch_top;
   import utils_top::*;

   localparam int unsigned DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_redir = 1'b0;
   logic [31:0] ex_redir_pc = '0;
   logic        id_rdy = 1'b0;
   logic        if_vld;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_bub_cnt;

   fetch_imem_if imem();

   fetch_top #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (imem),
      .ex_redir    (ex_redir),
      .ex_redir_pc (ex_redir_pc),
      .id_rdy      (id_rdy),
      .if_vld      (if_vld),
      .if_inst     (if_inst),
      .if_pc       (if_pc),
      .if_bub_cnt  (if_bub_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a request is in flight until answered; a redirect marks
   // every in-flight request stale. Kept words are counted in 'buffered' and
   // are consumed strictly in PC order starting from ref_pc.
   typedef struct {
      logic [31:0] addr;
      int unsigned ready;
      bit          stale;
   } fl_t;

   fl_t         inflight[$];
   logic [31:0] granted[$];
   logic [31:0] seen[$];
   int unsigned cyc;
   int unsigned buffered;
   int unsigned bub_exp;
   logic [31:0] ref_pc;
   logic [31:0] ref_fetch;
   logic        s_req;
   logic [31:0] s_addr;
   logic        s_vld;
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // One clock cycle: entered and left at posedge+1.
   task automatic cycle(input bit gnt_i, input bit rdy_i, input bit redir_i,
                        input logic [31:0] tgt, input int unsigned lat);
      bit          rv;
      bit          rstale;
      bit          exp_req;
      bit          exp_vld;
      int unsigned n_out;
      logic [31:0] exp_bub;
      n_out  = inflight.size();
      rv     = 1'b0;
      rstale = 1'b0;
      imem.rvld  = 1'b0;
      imem.rdata = '0;
      if (inflight.size() > 0 && inflight[0].ready <= cyc) begin
         rv         = 1'b1;
         rstale     = inflight[0].stale;
         imem.rvld  = 1'b1;
         imem.rdata = mem_word(inflight[0].addr);
         void'(inflight.pop_front());
      end
      imem.gnt    = gnt_i;
      id_rdy      = rdy_i;
      ex_redir    = redir_i;
      ex_redir_pc = tgt;
      #4;
      exp_vld = (buffered > 0);
      exp_req = !redir_i && (n_out + buffered < DEPTH);
      s_req   = imem.req;
      s_addr  = imem.addr;
      s_vld   = if_vld;
      n_cmp++;
      if (imem.req !== exp_req) begin
         n_err++;
         $display("FAIL req cyc%0d: got %b want %b", cyc, imem.req, exp_req);
      end
      if (exp_req) begin
         n_cmp++;
         if (imem.addr !== ref_fetch) begin
            n_err++;
            $display("FAIL addr cyc%0d: got %h want %h", cyc, imem.addr, ref_fetch);
         end
      end
      n_cmp++;
      if (if_vld !== exp_vld) begin
         n_err++;
         $display("FAIL if_vld cyc%0d: got %b want %b", cyc, if_vld, exp_vld);
      end
      if (exp_vld) begin
         n_cmp++;
         if (if_pc !== ref_pc || if_inst !== mem_word(ref_pc)) begin
            n_err++;
            $display("FAIL head cyc%0d: got pc %h inst %h want pc %h inst %h",
                     cyc, if_pc, if_inst, ref_pc, mem_word(ref_pc));
         end
      end else begin
         n_cmp++;
         if (if_inst !== NOP_INST) begin
            n_err++;
            $display("FAIL nop cyc%0d: got %h want %h", cyc, if_inst, NOP_INST);
         end
      end
`ifdef FETCH_BUBBLE_CNT_EN
      exp_bub = bub_exp;
`else
      exp_bub = '0;
`endif
      n_cmp++;
      if (if_bub_cnt !== exp_bub) begin
         n_err++;
         $display("FAIL bub_cnt cyc%0d: got %0d want %0d", cyc, if_bub_cnt, exp_bub);
      end
      if (!exp_vld) bub_exp++;
      if (redir_i) begin
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         buffered  = 0;
         ref_pc    = tgt & ~32'h3;
         ref_fetch = tgt & ~32'h3;
      end else begin
         if (rv && !rstale) buffered++;
         if (exp_vld && rdy_i) begin
            seen.push_back(ref_pc);
            buffered--;
            ref_pc += 32'd4;
         end
         if (exp_req && gnt_i) begin
            granted.push_back(ref_fetch);
            inflight.push_back('{ref_fetch, cyc + lat, 1'b0});
            ref_fetch += 32'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Asserts rst mid-cycle, checks the asynchronous clear, releases it.
   task automatic do_reset();
      imem.gnt = 1'b0; imem.rvld = 1'b0; imem.rdata = '0;
      ex_redir = 1'b0; id_rdy = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (imem.req !== 1'b0 || imem.addr !== RST_PC || if_vld !== 1'b0 ||
          if_inst !== NOP_INST || if_pc !== 32'h0 || if_bub_cnt !== 32'h0) begin
         n_err++;
         $display("FAIL async_reset: got req %b addr %h vld %b inst %h pc %h bub %0d want 0 %h 0 %h 0 0",
                  imem.req, imem.addr, if_vld, if_inst, if_pc, if_bub_cnt, RST_PC, NOP_INST);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      inflight.delete(); granted.delete(); seen.delete();
      buffered = 0; bub_exp = 0; cyc = 0;
      ref_pc = RST_PC; ref_fetch = RST_PC;
   endtask

   task automatic test_reset();
      imem.gnt = 1'b1; imem.rvld = 1'b1; imem.rdata = 32'hDEAD_BEEF;
      id_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (imem.req !== 1'b0 || imem.addr !== RST_PC || if_vld !== 1'b0 ||
             if_inst !== NOP_INST || if_pc !== 32'h0 || if_bub_cnt !== 32'h0) begin
            n_err++;
            $display("FAIL reset_hold: got req %b addr %h vld %b inst %h pc %h bub %0d",
                     imem.req, imem.addr, if_vld, if_inst, if_pc, if_bub_cnt);
         end
      end
      @(posedge clk);
      #1;
      do_reset();
   endtask

   task automatic test_stream();
      int first;
      first = -1;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, 1'b0, '0, 1);
         if (s_vld && first < 0) first = i;
      end
      n_cmp++;
      if (first !== 2) begin
         n_err++;
         $display("FAIL first_vld_cycle: got %0d want 2", first);
      end
      n_cmp++;
      if (seen.size() < 3 || seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8) begin
         n_err++;
         $display("FAIL stream_order: got %0d entries want 0,4,8 first", seen.size());
      end
   endtask

   task automatic test_stall();
      int ngr;
      ngr = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b0, 1'b0, '0, 1);
         if (s_req) ngr++;
      end
      n_cmp++;
      if (ngr !== 2 || s_req !== 1'b0) begin
         n_err++;
         $display("FAIL stall_grants: got %0d grants req %b want 2 grants req 0", ngr, s_req);
      end
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0, 1);
      n_cmp++;
      if (seen.size() < 2 || seen[0] !== 32'h0 || seen[1] !== 32'h4 ||
          granted.size() < 3 || granted[2] !== 32'h8) begin
         n_err++;
         $display("FAIL stall_resume: got %0d pops %0d grants want pops 0,4 then grant 8",
                  seen.size(), granted.size());
      end
   endtask

   task automatic test_gnt_hold();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0, '0, 1);
         n_cmp++;
         if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            n_err++;
            $display("FAIL gnt_hold %0d: got req %b addr %h want 1 0", i, s_req, s_addr);
         end
      end
      cycle(1'b1, 1'b1, 1'b0, '0, 1);
      cycle(1'b0, 1'b1, 1'b0, '0, 1);
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== 32'h4) begin
         n_err++;
         $display("FAIL gnt_advance: got req %b addr %h want 1 4", s_req, s_addr);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      cycle(1'b1, 1'b1, 1'b0, '0, 3);
      cycle(1'b1, 1'b1, 1'b0, '0, 3);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1);
      granted.delete(); seen.delete();
      cycle(1'b1, 1'b1, 1'b0, '0, 1);
      n_cmp++;
      if (s_vld !== 1'b0) begin
         n_err++;
         $display("FAIL redir_vld: got %b want 0", s_vld);
      end
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, '0, 1);
      n_cmp++;
      if (granted.size() < 1 || granted[0] !== 32'h100 || seen.size() < 1 || seen[0] !== 32'h100) begin
         n_err++;
         $display("FAIL redir_target: got %0d grants %0d pops want first 100", granted.size(), seen.size());
      end
   endtask

   task automatic test_redir_rvld();
      do_reset();
      cycle(1'b1, 1'b1, 1'b0, '0, 2);
      cycle(1'b1, 1'b1, 1'b0, '0, 3);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1);
      seen.delete();
      cycle(1'b1, 1'b1, 1'b0, '0, 1);
      n_cmp++;
      if (s_vld !== 1'b0) begin
         n_err++;
         $display("FAIL redir_rvld_vld: got %b want 0", s_vld);
      end
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, '0, 1);
      n_cmp++;
      if (seen.size() < 1 || seen[0] !== 32'h40) begin
         n_err++;
         $display("FAIL redir_rvld_first: got %0d pops want first 40", seen.size());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, '0, 1);
      n_cmp++;
      if (granted.size() < 2 || granted[0] !== 32'hFFFF_FFFC || granted[1] !== 32'h0 ||
          seen.size() < 2 || seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
         n_err++;
         $display("FAIL wrap: got %0d grants %0d pops want FFFFFFFC then 0", granted.size(), seen.size());
      end
   endtask

   task automatic test_bubble();
      logic [31:0] exp5;
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1);
`ifdef FETCH_BUBBLE_CNT_EN
      exp5 = 32'd5;
`else
      exp5 = 32'd0;
`endif
      n_cmp++;
      if (if_bub_cnt !== exp5) begin
         n_err++;
         $display("FAIL bubble_5: got %0d want %0d", if_bub_cnt, exp5);
      end
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0, 2);
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, '0, 1);
   endtask

   task automatic test_random();
      bit          g;
      bit          r;
      bit          rd;
      logic [31:0] t;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         g  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 3) != 0);
         rd = ($urandom_range(0, 19) == 0);
         t  = $urandom;
         cycle(g, r, rd, t, $urandom_range(1, 4));
      end
   endtask

   initial begin
      imem.gnt = 1'b0; imem.rvld = 1'b0; imem.rdata = '0;
      test_reset();
      test_stream();
      test_stall();
      test_gnt_hold();
      test_redirect();
      test_redir_rvld();
      test_wrap();
      test_bubble();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
